// File: rtl/register_reader.sv
// register_reader: streams selected registers of a flattened bank bus as valid/ready beats.
// Define REGISTER_READER_SNAPSHOT_EN to read from a bus shadow captured at start.
module register_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REG = 6,
   localparam int IDX_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1
) (
   input  logic                          clk,
   input  logic                          i_rst_n,
   input  logic [NUM_REG*DATA_WIDTH-1:0] i_read_data,
   input  logic                          i_start,
   input  logic [NUM_REG-1:0]            i_read_mask,
   input  logic                          i_ready,
   output logic                          o_valid,
   output logic [DATA_WIDTH-1:0]         o_data,
   output logic [IDX_W-1:0]              o_index,
   output logic                          o_last,
   output logic                          o_busy,
   output logic                          o_done
);
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
   state_t state;
   logic [NUM_REG-1:0] pend, nxt;
   logic [DATA_WIDTH-1:0] regs [NUM_REG];
   function automatic logic [IDX_W-1:0] lsb(input logic [NUM_REG-1:0] v);
      lsb = '0;
      for (int k = NUM_REG - 1; k >= 0; k--) if (v[k]) lsb = IDX_W'(k);
   endfunction
   function automatic logic one(input logic [NUM_REG-1:0] v);
      return v != '0 && (v & (v - NUM_REG'(1))) == '0;
   endfunction
`ifdef REGISTER_READER_SNAPSHOT_EN
   logic [NUM_REG*DATA_WIDTH-1:0] shadow;
   wire  [NUM_REG*DATA_WIDTH-1:0] src = shadow;
`else
   wire  [NUM_REG*DATA_WIDTH-1:0] src = i_read_data;
`endif
   for (genvar g = 0; g < NUM_REG; g++) begin : g_reg
      assign regs[g] = src[g*DATA_WIDTH +: DATA_WIDTH];
   end
   assign nxt = pend & ~(NUM_REG'(1) << o_index);
   assign o_data = o_valid ? regs[o_index] : '0;
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         pend    <= '0;
         o_valid <= 1'b0;
         o_index <= '0;
         o_last  <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
`ifdef REGISTER_READER_SNAPSHOT_EN
         shadow  <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (i_start) begin
               pend    <= i_read_mask;
               state   <= (|i_read_mask) ? SEND : DONE;
               o_valid <= |i_read_mask;
               o_index <= lsb(i_read_mask);
               o_last  <= one(i_read_mask);
               o_busy  <= 1'b1;
               o_done  <= ~|i_read_mask;
`ifdef REGISTER_READER_SNAPSHOT_EN
               shadow  <= i_read_data;
`endif
            end
            // outputs advance only on acceptance, so a waiting beat never changes
            SEND: if (i_ready) begin
               pend    <= nxt;
               o_index <= lsb(nxt);
               o_last  <= one(nxt);
               o_valid <= ~o_last;
               o_done  <= o_last;
               state   <= o_last ? DONE : SEND;
            end
            DONE: begin
               state  <= IDLE;
               o_busy <= 1'b0;
               o_done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_register_reader.sv
// tb_register_reader: directed checks of dump sequencing, backpressure, reset abort.
module tb_register_reader;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
   logic [47:0] rd = 48'h66_55_44_33_22_11;
   logic [5:0] mask = '0;
   logic valid, last, busy, done;
   logic [7:0] data;
   logic [2:0] index;
   int tests = 0, fails = 0;
   register_reader dut (
      .clk(clk), .i_rst_n(rst_n), .i_read_data(rd), .i_start(start), .i_read_mask(mask),
      .i_ready(ready), .o_valid(valid), .o_data(data), .o_index(index), .o_last(last),
      .o_busy(busy), .o_done(done)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_data"}, data, 0);
      chk({tag, "_index"}, index, 0);
      chk({tag, "_last"}, last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask
   initial begin
      start = 1'b1;
      mask = 6'h3F;
      repeat (3) step();
      chk_idle("rst");
      start = 1'b0;
      rst_n = 1'b1;
      step();
      chk_idle("post_rst");
      // full dump, ready held high
      start = 1'b1; mask = 6'h3F; ready = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("full_valid", valid, 1);
         chk("full_index", index, k);
         chk("full_data", data, 8'(8'h11 * (k + 1)));
         chk("full_last", last, k == 5);
         chk("full_busy", busy, 1);
         step();
      end
      chk("full_done", done, 1);
      chk("full_done_valid", valid, 0);
      chk("full_done_busy", busy, 1);
      step();
      chk("full_after_done", done, 0);
      chk("full_after_busy", busy, 0);
      // sparse mask with backpressure
      start = 1'b1; mask = 6'b100100; ready = 1'b0;
      step();
      start = 1'b0;
      chk("sp_idx2", index, 2); chk("sp_data2", data, 8'h33); chk("sp_last2", last, 0);
      step();
      chk("sp_hold_v2", valid, 1); chk("sp_hold_i2", index, 2); chk("sp_hold_d2", data, 8'h33);
      ready = 1'b1;
      step();
      chk("sp_idx5", index, 5); chk("sp_data5", data, 8'h66); chk("sp_last5", last, 1);
      ready = 1'b0;
      step();
      chk("sp_hold_v5", valid, 1); chk("sp_hold_i5", index, 5); chk("sp_hold_l5", last, 1);
      ready = 1'b1;
      step();
      chk("sp_done", done, 1); chk("sp_done_valid", valid, 0);
      step();
      chk("sp_idle_busy", busy, 0);
      // empty mask
      start = 1'b1; mask = 6'b0;
      step();
      start = 1'b0;
      chk("em_valid", valid, 0); chk("em_done", done, 1); chk("em_busy", busy, 1);
      step();
      chk("em_done_clr", done, 0); chk("em_busy_clr", busy, 0);
      // bank write after start, before the beat is accepted
      start = 1'b1; mask = 6'b001000; ready = 1'b0;
      step();
      start = 1'b0;
      chk("sn_idx", index, 3); chk("sn_data_pre", data, 8'h44); chk("sn_last", last, 1);
      rd[31:24] = 8'hAA;
      #1;
`ifdef REGISTER_READER_SNAPSHOT_EN
      chk("sn_data_post", data, 8'h44);
`else
      chk("sn_data_post", data, 8'hAA);
`endif
      ready = 1'b1;
      step();
      chk("sn_done", done, 1);
      rd[31:24] = 8'h44;
      step();
      // start pulsed mid-dump is ignored
      start = 1'b1; mask = 6'h3F;
      step();
      start = 1'b0;
      chk("ig_idx0", index, 0);
      step();
      start = 1'b1; mask = 6'b000001;
      chk("ig_idx1", index, 1);
      step();
      start = 1'b0;
      for (int k = 2; k < 6; k++) begin
         chk("ig_index", index, k);
         chk("ig_data", data, 8'(8'h11 * (k + 1)));
         step();
      end
      chk("ig_done", done, 1);
      step();
      chk("ig_idle", busy, 0);
      // reset during beat 2 aborts the dump
      start = 1'b1; mask = 6'h3F;
      step();
      start = 1'b0;
      step();
      step();
      chk("ab_idx2", index, 2);
      rst_n = 1'b0;
      #1;
      chk_idle("ab_rst");
      step();
      chk("ab_no_done", done, 0);
      rst_n = 1'b1;
      step();
      chk_idle("ab_idle");
      start = 1'b1; mask = 6'h3F;
      step();
      start = 1'b0;
      chk("re_valid", valid, 1); chk("re_idx0", index, 0); chk("re_data0", data, 8'h11);
      repeat (6) step();
      chk("re_done", done, 1);
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/register_reader.md
# register_reader

Streams the contents of the register bank's flattened read bus out as a sequence of single-register beats over a valid/ready handshake. It is the read-side counterpart to the bank: the bank is written one-hot with a broadcast word and exposes all registers on one wide bus, and this block walks that bus and emits one register per beat. Used for debug dumps and for feeding downstream consumers that take one word at a time. A start pulse launches a dump of the registers selected by a mask.

## Interface
- DATA_WIDTH, 8, bits per register
- NUM_REG, 6, number of registers on the bus; IDX_W = max(1, $clog2(NUM_REG))
- clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_read_data  input  NUM_REG*DATA_WIDTH  flattened bank bus; register k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_start  input  1  launch a dump; sampled only in IDLE
- i_read_mask  input  NUM_REG  bit k set = emit register k; sampled with i_start
- i_ready  input  1  consumer accepts beat when high with o_valid
- o_valid  output  1  beat present
- o_data  output  DATA_WIDTH  register value of current beat
- o_index  output  IDX_W  register number of current beat
- o_last  output  1  current beat is the final one of the dump
- o_busy  output  1  high in SEND and DONE
- o_done  output  1  one-cycle pulse at end of every dump

## Operation
- FSM states: IDLE, SEND, DONE.
- IDLE: i_start=1 at edge → latch i_read_mask into pending mask (and bus snapshot, see Configuration); go SEND if mask≠0, else DONE.
- SEND: current index = lowest set bit of pending mask. o_valid=1, o_index=that bit, o_data=that register, o_last=1 iff exactly one pending bit remains.
- Beat accepted on edge with o_valid && i_ready: clear that pending bit; if o_last, go DONE, else stay SEND with next-lowest bit.
- o_valid, once high, stays high with o_data/o_index/o_last stable until accepted (no retraction).
- DONE: o_done=1, o_valid=0 for exactly one cycle; then IDLE.
- i_start outside IDLE ignored entirely; i_read_mask ignored outside the start cycle.
- Bits of i_read_mask ≥ NUM_REG do not exist; index never exceeds NUM_REG-1.

## Timing
- Reset (async assert, any state, including mid-dump): state=IDLE, pending mask=0, snapshot=0; o_valid=0, o_data=0, o_index=0, o_last=0, o_busy=0, o_done=0. Aborted dump produces no o_done.
- Start latency: i_start sampled at edge N → first o_valid high in cycle after edge N.
- Throughput: one beat per cycle when i_ready held high; M selected registers → M consecutive valid cycles.
- o_done in the cycle following acceptance of the last beat; IDLE the cycle after; new i_start accepted there.
- Empty mask: o_busy and o_done high for one cycle after start edge, no beats.
- Outputs are functions of registered state only (no combinational path from i_ready to o_valid/o_data).

## Configuration
- REGISTER_READER_SNAPSHOT_EN defined: full NUM_REG*DATA_WIDTH shadow captured at start edge; o_data comes from the shadow, so bank writes during a dump are invisible.
- Not defined: no shadow storage; o_data = live i_read_data slice at current index. Consumer sees latest bank value at acceptance; o_data may change while o_valid waits for i_ready (sole exception to stability rule).

## Test plan
- Reset: hold i_rst_n=0 with i_start=1, mask 6'h3F → all outputs 0, no beats; release, IDLE.
- Full dump: bus regs 0..5 = 11,22,33,44,55,66 (hex), mask 6'b111111, i_ready=1 → six consecutive beats idx 0..5, data 11..66, o_last only on idx 5, o_done next cycle, o_busy low after.
- Sparse with backpressure: mask 6'b100100, i_ready toggling 0/1 → beats idx 2 data 33 then idx 5 data 66 (o_last), each held stable while i_ready=0.
- Empty mask: i_start with mask 0 → no o_valid, o_done and o_busy high exactly one cycle after start.
- Snapshot: after start, write reg 3 to AA before its beat → with macro beat idx 3 carries 44; without macro carries AA.
- Abort/ignore: i_start pulsed during SEND → ignored, dump unchanged; i_rst_n low during beat 2 of full dump → outputs 0 immediately, no o_done; next start dumps from idx 0.
